// File: rtl/booth_multiplication.sv
`default_nettype none
// ============================================================================
// Module      : booth_multiplication
// Description : Sequential 32x32 signed multiplier using radix-2 Booth
//               recoding. One Booth iteration per clock, 32 iterations.
//               Sequence: IDLE -> INIT (load operands) -> RUN x32 -> DONE.
// Ports       : GO     - start request, registered before the FSM sees it
//               clk    - clock, rising edge
//               RST    - synchronous active-high reset
//               m, r   - multiplicand / multiplier (two's complement)
//               done   - high while in DONE
//               cntOut - high during the final RUN iteration
//               pOut   - current Booth pair {Q[0], Q_-1}
//               CS     - state: IDLE=00 INIT=01 RUN=10 DONE=11
//               result - signed 64-bit product {A[31:0], Q}
// Options     : `define BOOTH_AUTO_RESTART_EN makes DONE last one cycle
//               regardless of GO; otherwise DONE is held until GO drops.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_multiplication (
  input  logic        GO,
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] m,
  input  logic [31:0] r,
  output logic        done,
  output logic        cntOut,
  output logic [1:0]  pOut,
  output logic [1:0]  CS,
  output logic [63:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_INIT = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [4:0] c_LAST_ITER = 5'd31;

  state_t      r_state;
  logic        r_go;
  logic [32:0] r_m;
  logic [32:0] r_a;
  logic [31:0] r_q;
  logic        r_qm1;
  logic [4:0]  r_cnt;

  logic [32:0] w_addend;
  logic [32:0] w_sum;

  // GO is captured one edge before the FSM acts on it. It is deliberately
  // sampled even while RST is high, so a GO held through reset release
  // starts a new operation on the first edge after release.
  always_ff @(posedge clk) begin
    r_go <= GO;
  end

  // Booth recoding: 01 adds M, 10 subtracts M, 00/11 adds nothing.
  // A is 33 bits wide so that -M for m=0x80000000 is representable.
  always_comb begin
    w_addend = 33'd0;
    case ({r_q[0], r_qm1})
      2'b01:   w_addend = r_m;
      2'b10:   w_addend = ~r_m + 33'd1;
      default: w_addend = 33'd0;
    endcase
    w_sum = r_a + w_addend;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_m     <= 33'd0;
      r_a     <= 33'd0;
      r_q     <= 32'd0;
      r_qm1   <= 1'b0;
      r_cnt   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_go) begin
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_m     <= {m[31], m};
          r_a     <= 33'd0;
          r_q     <= r;
          r_qm1   <= 1'b0;
          r_cnt   <= 5'd0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          // Add/subtract and arithmetic right shift of {A,Q,Q_-1} in one step.
          r_a   <= {w_sum[32], w_sum[32:1]};
          r_q   <= {w_sum[0], r_q[31:1]};
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == c_LAST_ITER) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
`ifdef BOOTH_AUTO_RESTART_EN
          r_state <= S_IDLE;
`else
          if (!r_go) begin
            r_state <= S_IDLE;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign CS     = r_state;
  assign done   = (r_state == S_DONE);
  assign cntOut = (r_state == S_RUN) && (r_cnt == c_LAST_ITER);
  assign pOut   = {r_q[0], r_qm1};
  assign result = {r_a[31:0], r_q};

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplication.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_multiplication
// Description : Self-checking bench for booth_multiplication. Expected
//               products come from plain signed 64-bit multiplication;
//               expected state timing comes from the operation schedule
//               (INIT after edge 1, RUN after edges 2..33, DONE after 34).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_multiplication;

  logic        clk;
  logic        RST;
  logic        GO;
  logic [31:0] m;
  logic [31:0] r;
  logic        done;
  logic        cntOut;
  logic [1:0]  pOut;
  logic [1:0]  CS;
  logic [63:0] result;

  int          n_vec;
  int          n_err;
  logic [63:0] last_exp;

  booth_multiplication dut (
    .GO     (GO),
    .clk    (clk),
    .RST    (RST),
    .m      (m),
    .r      (r),
    .done   (done),
    .cntOut (cntOut),
    .pOut   (pOut),
    .CS     (CS),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  // Bounded wait until the DUT is back in IDLE, then one extra edge so the
  // registered copy of GO reflects GO=0.
  task automatic wait_idle();
    int k;
    GO = 1'b0;
    k  = 0;
    while (CS !== 2'b00 && k < 100) begin
      tick();
      k++;
    end
    n_vec++;
    if (CS !== 2'b00) begin
      n_err++;
      $display("FAIL wait_idle: CS=%b after %0d cycles, required 00", CS, k);
    end
    tick();
  endtask

  // One complete multiplication with exact cycle-by-cycle expectations.
  // scramble: wiggle GO/m/r after operands have been loaded (must be ignored).
  // hold: leave GO high when DONE is reached.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, input bit hold);
    logic [63:0] exp;
    exp = ref_mul(a, b);
    m  = a;
    r  = b;
    GO = 1'b1;
    tick();                                   // edge 0: GO captured
    n_vec++;
    if (CS !== 2'b00) begin
      n_err++; $display("FAIL lat_edge0: CS=%b required 00", CS);
    end
    tick();                                   // edge 1
    n_vec++;
    if (CS !== 2'b01) begin
      n_err++; $display("FAIL lat_init: CS=%b required 01", CS);
    end
    for (int e = 2; e <= 33; e++) begin
      tick();
      n_vec++;
      if (CS !== 2'b10 || cntOut !== (e == 33) || done !== 1'b0) begin
        n_err++;
        $display("FAIL lat_run edge %0d: CS=%b cntOut=%b done=%b required 10/%b/0",
                 e, CS, cntOut, done, (e == 33));
      end
      if (e == 2) begin
        n_vec++;
        if (pOut !== {b[0], 1'b0}) begin
          n_err++; $display("FAIL pair_first: pOut=%b required %b", pOut, {b[0], 1'b0});
        end
      end
      if (scramble) begin
        m  = $urandom;
        r  = $urandom;
        GO = (e >= 31) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
    tick();                                   // edge 34
    n_vec++;
    if (CS !== 2'b11 || done !== 1'b1 || result !== exp) begin
      n_err++;
      $display("FAIL product %h*%h: CS=%b done=%b result=%h required 11/1/%h",
               a, b, CS, done, result, exp);
    end
    last_exp = exp;
    if (!hold) GO = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; GO = 1'b0; m = 32'hDEADBEEF; r = 32'h12345678;
    tick(); tick(); tick();
    n_vec++;
    if (CS !== 2'b00 || done !== 1'b0 || cntOut !== 1'b0 || pOut !== 2'b00 || result !== 64'd0) begin
      n_err++;
      $display("FAIL reset: CS=%b done=%b cntOut=%b pOut=%b result=%h required 00/0/0/00/0",
               CS, done, cntOut, pOut, result);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_op(32'hFFFFFFFD, 32'hFFFFFFFC, 1'b0, 1'b0);
    n_vec++;
    if (last_exp !== 64'h000000000000000C) begin
      n_err++; $display("FAIL model_neg3_neg4: got %h required 000000000000000c", last_exp);
    end
    wait_idle();
    run_op(32'd7, 32'hFFFFFFFB, 1'b0, 1'b0);
    wait_idle();
    run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0);
    wait_idle();
    run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0);
    wait_idle();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 0) a = 32'd0;
      if (i == 1) b = 32'hFFFFFFFF;
      run_op(a, b, 1'b1, 1'b0);
      wait_idle();
    end
  endtask

  task automatic test_idle_retain();
    run_op(32'h00012345, 32'hFFFF0F0F, 1'b0, 1'b0);
    wait_idle();
    tick(); tick();
    n_vec++;
    if (CS !== 2'b00 || done !== 1'b0 || result !== last_exp) begin
      n_err++;
      $display("FAIL idle_retain: CS=%b done=%b result=%h required 00/0/%h",
               CS, done, result, last_exp);
    end
  endtask

  task automatic test_go_hold();
    run_op($urandom, $urandom, 1'b0, 1'b1);
`ifdef BOOTH_AUTO_RESTART_EN
    tick();
    n_vec++;
    if (CS !== 2'b00 || done !== 1'b0) begin
      n_err++; $display("FAIL go_hold_auto: CS=%b done=%b required 00/0", CS, done);
    end
`else
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (CS !== 2'b11 || done !== 1'b1 || result !== last_exp) begin
        n_err++;
        $display("FAIL go_hold cycle %0d: CS=%b done=%b result=%h required 11/1/%h",
                 k, CS, done, result, last_exp);
      end
    end
`endif
    wait_idle();
  endtask

  task automatic test_reset_midrun();
    m = 32'h0000ABCD; r = 32'hFFFFF123; GO = 1'b1;
    tick(); tick();                           // edges 0,1 -> INIT
    for (int e = 2; e <= 12; e++) tick();     // ten-plus RUN iterations
    RST = 1'b1; GO = 1'b0;
    tick();
    n_vec++;
    if (CS !== 2'b00 || done !== 1'b0 || cntOut !== 1'b0 || result !== 64'd0) begin
      n_err++;
      $display("FAIL reset_midrun: CS=%b done=%b cntOut=%b result=%h required 00/0/0/0",
               CS, done, cntOut, result);
    end
    RST = 1'b0;
    tick();
    run_op(32'h0000ABCD, 32'hFFFFF123, 1'b0, 1'b0);
    wait_idle();
  endtask

  task automatic test_go_through_reset();
    logic [63:0] exp;
    int k;
    m = 32'hFFFFF000; r = 32'h00000321; GO = 1'b1; RST = 1'b1;
    exp = ref_mul(32'hFFFFF000, 32'h00000321);
    tick(); tick();
    n_vec++;
    if (CS !== 2'b00) begin
      n_err++; $display("FAIL go_in_reset: CS=%b required 00", CS);
    end
    RST = 1'b0;
    tick();
    n_vec++;
    if (CS !== 2'b01) begin
      n_err++; $display("FAIL go_through_reset: CS=%b required 01", CS);
    end
    tick();                                   // operands loaded on this edge
    GO = 1'b0;
    k = 0;
    while (CS !== 2'b11 && k < 60) begin
      tick();
      k++;
    end
    n_vec++;
    if (CS !== 2'b11 || result !== exp) begin
      n_err++;
      $display("FAIL go_through_reset_product: CS=%b result=%h required 11/%h", CS, result, exp);
    end
    wait_idle();
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    last_exp = 64'd0;
    RST = 1'b1; GO = 1'b0; m = 32'd0; r = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_idle_retain();
    test_go_hold();
    test_reset_midrun();
    test_go_through_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
